// File: rtl/regfile_mp_if.sv
// Register-file bus: two write ports, packed read ports, and sweep-clear control.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic                           ctrl_writeEnable0;
  logic [ADDR_WIDTH-1:0]          ctrl_writeReg0;
  logic [DATA_WIDTH-1:0]          data_writeReg0;
  logic                           ctrl_writeEnable1;
  logic [ADDR_WIDTH-1:0]          ctrl_writeReg1;
  logic [DATA_WIDTH-1:0]          data_writeReg1;
  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg;
  logic [NUM_READ*DATA_WIDTH-1:0] data_readReg;
  logic                           ctrl_clear;
  logic                           clear_busy;
  logic                           write_dropped;

  modport master (
    output ctrl_writeEnable0, ctrl_writeReg0, data_writeReg0,
    output ctrl_writeEnable1, ctrl_writeReg1, data_writeReg1,
    output ctrl_readReg, ctrl_clear,
    input  data_readReg, clear_busy, write_dropped
  );

  modport slave (
    input  ctrl_writeEnable0, ctrl_writeReg0, data_writeReg0,
    input  ctrl_writeEnable1, ctrl_writeReg1, data_writeReg1,
    input  ctrl_readReg, ctrl_clear,
    output data_readReg, clear_busy, write_dropped
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ combinational reads, two write ports
// (port 1 has priority), optional write-to-read bypass and a sweep-clear engine
// that zeroes one entry per cycle without needing the global reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | normal operation, writes and bypass active
// S_CLEAR | sweeping entries to zero, writes dropped, bypass disabled
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic         clock,
  input  logic         ctrl_reset,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  write_dropped_q;
  logic                  idle;
  logic                  wr0_ok;
  logic                  wr1_ok;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  assign addr0 = bus.ctrl_writeReg0;
  assign addr1 = bus.ctrl_writeReg1;
  assign data0 = bus.data_writeReg0;
  assign data1 = bus.data_writeReg1;
  assign idle  = (state == S_IDLE);

  // Qualify each write port: drop writes to the hardwired zero register, and
  // drop port 0 when port 1 targets the same entry so only one write lands.
  always_comb begin
    wr1_ok = bus.ctrl_writeEnable1 && !((ZERO_REG != 0) && (addr1 == '0));
    wr0_ok = bus.ctrl_writeEnable0 && !((ZERO_REG != 0) && (addr0 == '0))
             && !(bus.ctrl_writeEnable1 && (addr1 == addr0));
  end

  // Sweep FSM; a write attempt during the sweep flags a one-cycle drop pulse.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state           <= S_IDLE;
      ptr             <= '0;
      write_dropped_q <= 1'b0;
    end else begin
      write_dropped_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ctrl_clear) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end
        end
        S_CLEAR: begin
          write_dropped_q <= bus.ctrl_writeEnable0 || bus.ctrl_writeEnable1;
          if (ptr == '1) state <= S_IDLE;
          else           ptr   <= ptr + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;

    // One entry: the sweep owns it during CLEAR, otherwise port 1 beats port 0.
    always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
        q <= '0;
      end else if (!idle) begin
        if (ptr == ADDR_WIDTH'(i)) q <= '0;
      end else if (wr1_ok && (addr1 == ADDR_WIDTH'(i))) begin
        q <= data1;
      end else if (wr0_ok && (addr0 == ADDR_WIDTH'(i))) begin
        q <= data0;
      end
    end

    assign regs[i] = q;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = bus.ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Read mux: stored value, overridden by in-flight write data, then by the zero register.
    always_comb begin
      rd = regs[ra];
      if ((BYPASS != 0) && idle) begin
        if (wr1_ok && (ra == addr1))      rd = data1;
        else if (wr0_ok && (ra == addr0)) rd = data0;
      end
      if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
    end

    assign bus.data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

  assign bus.clear_busy    = (state == S_CLEAR);
  assign bus.write_dropped = write_dropped_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 32x32 2-read build with bypass and a
// 8x16 4-read build without bypass, checked through an expectation queue.
module tb_regfile_mp;
  logic clock = 1'b0;
  logic ctrl_reset;

  always #5 clock = ~clock;

  regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus ();
  regfile_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4)) bus_b ();

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus)
  );

  regfile_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus_b)
  );

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    tag = tag_q.pop_front();
    e   = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ctrl_writeEnable0 = 1'b0; bus.ctrl_writeReg0 = '0; bus.data_writeReg0 = '0;
    bus.ctrl_writeEnable1 = 1'b0; bus.ctrl_writeReg1 = '0; bus.data_writeReg1 = '0;
    bus.ctrl_clear = 1'b0;
    bus_b.ctrl_writeEnable0 = 1'b0; bus_b.ctrl_writeReg0 = '0; bus_b.data_writeReg0 = '0;
    bus_b.ctrl_writeEnable1 = 1'b0; bus_b.ctrl_writeReg1 = '0; bus_b.data_writeReg1 = '0;
    bus_b.ctrl_clear = 1'b0;
  endtask

  task automatic rd_a(input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1, input string tag);
    expect_val({tag, "_p0"}, e0);
    expect_val({tag, "_p1"}, e1);
    bus.ctrl_readReg = {a1, a0};
    #1;
    check(bus.data_readReg[31:0]);
    check(bus.data_readReg[63:32]);
  endtask

  task automatic rd_b(input logic [2:0] a, input logic [15:0] e, input string tag);
    for (int k = 0; k < 4; k++) expect_val($sformatf("%s_p%0d", tag, k), 32'(e));
    bus_b.ctrl_readReg = {4{a}};
    #1;
    for (int k = 0; k < 4; k++) check(32'(bus_b.data_readReg[k*16 +: 16]));
  endtask

  initial begin
    int n;
    idle_inputs();
    bus.ctrl_readReg = '0;
    bus_b.ctrl_readReg = '0;
    ctrl_reset = 1'b1;
    repeat (2) tick();
    ctrl_reset = 1'b0;
    #1;

    // reset state
    expect_val("rst_busy", 32'd0); check(32'(bus.clear_busy));
    expect_val("rst_drop", 32'd0); check(32'(bus.write_dropped));
    rd_a(5'd5, 5'd31, 32'd0, 32'd0, "rst_read");

    // single write then read on both ports
    bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd5; bus.data_writeReg0 = 32'hDEADBEEF;
    tick(); idle_inputs();
    rd_a(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, "t1_r5");

    // same-address collision: port 1 wins
    bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd7; bus.data_writeReg0 = 32'h11;
    bus.ctrl_writeEnable1 = 1'b1; bus.ctrl_writeReg1 = 5'd7; bus.data_writeReg1 = 32'h22;
    tick(); idle_inputs();
    rd_a(5'd7, 5'd5, 32'h22, 32'hDEADBEEF, "t2_pri");

    // independent addresses on both write ports
    bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd8; bus.data_writeReg0 = 32'h88;
    bus.ctrl_writeEnable1 = 1'b1; bus.ctrl_writeReg1 = 5'd6; bus.data_writeReg1 = 32'h66;
    tick(); idle_inputs();
    rd_a(5'd8, 5'd6, 32'h88, 32'h66, "t2_dual");

    // register 0 stays zero
    bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd0; bus.data_writeReg0 = 32'hFF;
    tick(); idle_inputs();
    rd_a(5'd0, 5'd7, 32'd0, 32'h22, "t2_zero");

    // bypass: in-flight write visible before the edge
    bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd3; bus.data_writeReg0 = 32'hA5;
    rd_a(5'd3, 5'd2, 32'hA5, 32'd0, "t3_byp");
    tick(); idle_inputs();
    rd_a(5'd3, 5'd3, 32'hA5, 32'hA5, "t3_stored");
    bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd4; bus.data_writeReg0 = 32'h1;
    bus.ctrl_writeEnable1 = 1'b1; bus.ctrl_writeReg1 = 5'd4; bus.data_writeReg1 = 32'h2;
    rd_a(5'd4, 5'd4, 32'h2, 32'h2, "t3_byp_pri");
    tick(); idle_inputs();
    bus.ctrl_writeEnable1 = 1'b1; bus.ctrl_writeReg1 = 5'd0; bus.data_writeReg1 = 32'h77;
    rd_a(5'd0, 5'd4, 32'd0, 32'h2, "t3_byp_zero");
    tick(); idle_inputs();

    // narrow build without bypass
    bus_b.ctrl_writeEnable0 = 1'b1; bus_b.ctrl_writeReg0 = 3'd5; bus_b.data_writeReg0 = 16'hBEEF;
    tick(); idle_inputs();
    rd_b(3'd5, 16'hBEEF, "b_t1");
    bus_b.ctrl_writeEnable0 = 1'b1; bus_b.ctrl_writeReg0 = 3'd7; bus_b.data_writeReg0 = 16'h11;
    bus_b.ctrl_writeEnable1 = 1'b1; bus_b.ctrl_writeReg1 = 3'd7; bus_b.data_writeReg1 = 16'h22;
    tick(); idle_inputs();
    rd_b(3'd7, 16'h22, "b_t2_pri");
    bus_b.ctrl_writeEnable0 = 1'b1; bus_b.ctrl_writeReg0 = 3'd0; bus_b.data_writeReg0 = 16'hFF;
    tick(); idle_inputs();
    rd_b(3'd0, 16'h0, "b_t2_zero");
    bus_b.ctrl_writeEnable0 = 1'b1; bus_b.ctrl_writeReg0 = 3'd3; bus_b.data_writeReg0 = 16'hA5;
    rd_b(3'd3, 16'h0, "b_t3_nobyp");
    tick(); idle_inputs();
    rd_b(3'd3, 16'hA5, "b_t3_after");

    for (int i = 1; i < 8; i++) begin
      bus_b.ctrl_writeEnable0 = 1'b1; bus_b.ctrl_writeReg0 = 3'(i); bus_b.data_writeReg0 = 16'(i);
      tick();
    end
    idle_inputs();
    bus_b.ctrl_clear = 1'b1;
    tick(); idle_inputs();
    n = 0;
    while (bus_b.clear_busy && n < 40) begin
      case (n)
        2: begin
          bus_b.ctrl_writeEnable0 = 1'b1; bus_b.ctrl_writeReg0 = 3'd6; bus_b.data_writeReg0 = 16'h66;
        end
        3: begin
          idle_inputs();
          expect_val("b_drop", 32'd1); check(32'(bus_b.write_dropped));
        end
        4: bus_b.ctrl_clear = 1'b1;
        5: begin
          bus_b.ctrl_clear = 1'b0;
          rd_b(3'd7, 16'd7, "b_mid");
        end
        default: ;
      endcase
      n++;
      tick();
    end
    idle_inputs();
    expect_val("b_busy_len", 32'd8); check(32'(n));
    for (int a = 0; a < 8; a++) rd_b(3'(a), 16'h0, $sformatf("b_post_r%0d", a));

    // sweep clear on the wide build; r31 written in the same edge as the clear
    for (int i = 1; i < 31; i += 2) begin
      bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'(i);     bus.data_writeReg0 = 32'(i);
      bus.ctrl_writeEnable1 = 1'b1; bus.ctrl_writeReg1 = 5'(i + 1); bus.data_writeReg1 = 32'(i + 1);
      tick();
    end
    idle_inputs();
    bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd31; bus.data_writeReg0 = 32'd31;
    bus.ctrl_clear = 1'b1;
    tick(); idle_inputs();
    n = 0;
    while (bus.clear_busy && n < 64) begin
      case (n)
        3: begin
          bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd9; bus.data_writeReg0 = 32'h99;
          rd_a(5'd9, 5'd1, 32'd9, 32'd0, "t5_rd_clear");
        end
        4: begin
          idle_inputs();
          expect_val("t5_drop_hi", 32'd1); check(32'(bus.write_dropped));
        end
        5: begin
          expect_val("t5_drop_lo", 32'd0); check(32'(bus.write_dropped));
        end
        10: bus.ctrl_clear = 1'b1;
        11: bus.ctrl_clear = 1'b0;
        12: rd_a(5'd31, 5'd20, 32'd31, 32'd20, "t4_mid");
        default: ;
      endcase
      n++;
      tick();
    end
    idle_inputs();
    expect_val("t4_busy_len", 32'd32); check(32'(n));
    for (int a = 0; a < 32; a++) rd_a(5'(a), 5'(31 - a), 32'd0, 32'd0, $sformatf("t4_post_r%0d", a));

    // asynchronous reset in the middle of a sweep
    bus.ctrl_writeEnable0 = 1'b1; bus.ctrl_writeReg0 = 5'd5;  bus.data_writeReg0 = 32'h1234;
    bus.ctrl_writeEnable1 = 1'b1; bus.ctrl_writeReg1 = 5'd31; bus.data_writeReg1 = 32'h5678;
    tick(); idle_inputs();
    bus.ctrl_clear = 1'b1;
    tick(); idle_inputs();
    tick(); tick();
    #2;
    ctrl_reset = 1'b1;
    #1;
    expect_val("t6_busy", 32'd0); check(32'(bus.clear_busy));
    rd_a(5'd5, 5'd31, 32'd0, 32'd0, "t6_rst_read");
    ctrl_reset = 1'b0;
    tick();
    expect_val("t6_busy_after", 32'd0); check(32'(bus.clear_busy));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
